fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares the write port of one sync_fifo between NUM_REQ producers.
//   - Arbitration is round-robin and packet-atomic: a grant is held until the granted
//     producer's last beat.
//   - Writes are gated on fifo_full. A new packet only starts while fifo_almost_full is low.
//   - A stalled producer (valid dropped mid-packet) loses its grant after TIMEOUT cycles.
//   Sits between the producer valid/ready interfaces and the sync_fifo wr_en/din/full/almost_full.
// PARAMETERS
//   NUM_REQ  4   number of producers (>=2)
//   WIDTH    32  data width; must match the FIFO WIDTH
//   TIMEOUT  16  idle cycles in a packet before the grant is revoked; 0 disables the timeout
// PORTS
//   clk               in   1              clock, rising edge
//   rst_n             in   1              asynchronous, active-low reset
//   req_valid         in   NUM_REQ        per-producer beat valid
//   req_last          in   NUM_REQ        per-producer last beat of packet (qualified by valid)
//   req_data          in   NUM_REQ*WIDTH  producer i occupies bits [i*WIDTH +: WIDTH]
//   req_ready         out  NUM_REQ        per-producer beat accepted when valid&ready
//   fifo_wr_en        out  1              to FIFO wr_en
//   fifo_din          out  WIDTH          to FIFO din
//   fifo_full         in   1              from FIFO full
//   fifo_almost_full  in   1              from FIFO almost_full
//   grant_id          out  IDW            current owner, IDW = max(1,$clog2(NUM_REQ))
//   busy              out  1              1 while in BURST
//   err_timeout       out  1              one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//   Reset (async assert, sync deassert): state=IDLE, rr_ptr=0, grant_id=0, busy=0,
//     err_timeout=0, idle_cnt=0. Under reset: req_ready=0 and fifo_wr_en=0.
//   IDLE
//     - req_ready=0 and fifo_wr_en=0.
//     - If |req_valid and !fifo_almost_full: pick the first valid index searching from rr_ptr
//       upward, with wrap-around.
//     - At the next edge: grant_id=winner, state=BURST. This costs one arbitration cycle,
//       so there is one bubble between packets.
//   BURST (g = grant_id)
//     - req_ready[g] = !fifo_full. Every other req_ready bit is 0.
//     - fifo_wr_en = req_valid[g] & !fifo_full. This path is combinational (zero latency).
//     - fifo_din = req_data[g], driven whenever in BURST.
//     - fifo_almost_full is ignored mid-packet; only fifo_full stalls.
//     - Accepted beat with req_last[g]=1: state=IDLE, rr_ptr=(g+1)%NUM_REQ. A single-beat
//       packet is legal.
//   Timeout
//     - idle_cnt counts BURST cycles with req_valid[g]=0 and clears on any accepted beat.
//     - Cycles where the beat is present but fifo_full=1 do NOT count.
//     - When idle_cnt reaches TIMEOUT-1 with valid still low: err_timeout=1 for one cycle,
//       state=IDLE, rr_ptr=(g+1)%NUM_REQ, idle_cnt=0.
//     - The remainder of the packet is the producer's problem. Its later beats re-arbitrate
//       as a new packet.
//   Other rules
//     - fifo_wr_en is never asserted while fifo_full=1, so overflow is impossible by
//       construction.
//     - req_valid and req_last from non-granted producers are ignored.
//     - rr_ptr advances only on packet end or timeout, never on grant.
//     - Reset mid-packet aborts immediately: outputs return to reset values; no partial
//       beat is written.
// STRUCTURE
//   Package fifo_arb_pkg holds:
//     - typedef enum logic {IDLE, BURST} arb_state_t;
//     - function idw(n) returning max(1,$clog2(n)).
//   Sub-module rr_pick: a combinational rotate-priority search.
//     - Inputs: req[NUM_REQ], ptr.
//     - Outputs: found and idx.
//   The top module holds the FSM, rr_ptr, idle_cnt, and the data/ready muxing.
// TESTING (NUM_REQ=4, WIDTH=32, TIMEOUT=4, sync_fifo DEPTH=32 FULL_THRESHOLD=8)
//   1. Producer 1 sends 4 beats 0xA0..0xA3, last on 0xA3
//      -> grant_id=1 one cycle after valid; fifo_wr_en high 4 consecutive cycles;
//         FIFO reads back A0..A3; busy falls after the last beat.
//   2. All 4 producers continuously offer 2-beat packets
//      -> grant order 0,1,2,3,0; exactly one idle cycle between packets; no interleaving
//         of beats from different producers.
//   3. Hold fifo_almost_full=1 in IDLE with requests pending
//      -> no grant. Assert it mid-packet -> the packet completes. Force fifo_full=1 for
//         3 cycles -> req_ready=0, fifo_wr_en=0, no data loss, resume on release.
//   4. Producer 2 sends 1 beat (no last), then drops valid
//      -> err_timeout pulses after 4 idle cycles; the next grant goes to producer 3
//         if it is valid. A full-stall-only gap of 10 cycles does not trigger the timeout.
//   5. Assert rst_n low mid-burst between clock edges
//      -> busy, req_ready and fifo_wr_en go to 0 immediately. After release the first
//         grant goes to producer 0 (rr_ptr=0).

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the FIFO write-port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE between packets, BURST while a
//                   producer owns the FIFO write port)
//   - idw(n)      : index width needed to name one of n producers, never 0
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority search: returns the first asserted request
//   at or above ptr, wrapping past NUM_REQ-1 back to 0.
// Ports
//   req    in   NUM_REQ  request vector
//   ptr    in   IDW      index with highest priority
//   found  out  1        at least one request asserted
//   idx    out  IDW      winning index (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one sync_fifo write port between NUM_REQ producers. Grants are
//   round-robin and held for a whole packet; a producer that stops offering
//   beats mid-packet loses the grant after TIMEOUT idle cycles (0 = never).
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/last    per-producer beat valid and last-beat flag
//   req_data          producer i on bits [i*WIDTH +: WIDTH]
//   req_ready         per-producer accept, only the owner can see it high
//   fifo_wr_en/din    FIFO write strobe and data (combinational from owner)
//   fifo_full         stalls the current beat
//   fifo_almost_full  blocks the start of a new packet
//   grant_id          current / most recent owner
//   busy              high while a packet owns the port
//   err_timeout       one-cycle pulse when a grant is revoked by timeout
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    parameter  int TIMEOUT = 16,
    localparam int IDW     = idw(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_din,
    input  logic                     fifo_full,
    input  logic                     fifo_almost_full,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = TO_M1[CNT_W-1:0];

    arb_state_t       state_q, state_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Pointer moves past the owner only when its packet ends or is revoked.
    assign next_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

    // Write path is combinational from the owner so a beat lands in the
    // same cycle it is offered; state_q resets asynchronously, so these
    // drop to zero the moment rst_n falls.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = req_data[int'(grant_id_q) * WIDTH +: WIDTH];
        if (state_q == BURST) begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_wr_en            = req_valid[grant_id_q] & !fifo_full;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && !fifo_almost_full) begin
                    state_d    = BURST;
                    grant_id_d = pick_idx;
                    idle_cnt_d = '0;
                end
            end
            BURST: begin
                if (fifo_wr_en) begin
                    idle_cnt_d = '0;
                    if (req_last[grant_id_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (!req_valid[grant_id_q] && (TIMEOUT != 0)) begin
                    // A beat held back only by fifo_full is not idleness.
                    if (idle_cnt_q == TO_LAST) begin
                        err_d      = 1'b1;
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BURST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule
